ein_frame_fetch: RTL and testbench

Upstream feeder for the EIN pad modulator. It pops bytes of a received ICE frame from the bus-interface input buffer and parses a 3-byte header (type, event ID, length). It then prefetches the payload into a 4-entry FIFO that the modulator drains through a read-enable/empty handshake. It holds `header_done` for the full life of an accepted frame, so the ack state machine can fire on its falling edge.

---
 rtl/ein_frame_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_ein_frame_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ein_frame_fetch.sv
// ICE frame fetcher: parses a 3-byte header and prefetches the payload into a small FIFO.
// Optional payload length checking is built when EIN_FETCH_LEN_CHECK_EN is defined.
module ein_frame_fetch #(
   parameter logic [7:0]  MSG_TYPE   = 8'h65,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_next,
   output logic [7:0] out_data,
   output logic       out_empty,
   input  logic       out_re,
   output logic       header_done,
   output logic [7:0] header_eid,
   output logic       is_fragment,
   output logic       frame_dropped,
   output logic       length_error
);

   localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW = IdxW + 1;

   typedef enum logic [2:0] {
      StIdle,
      StHEid,
      StHLen,
      StPayload,
      StFlush,
      StDiscard
   } state_e;

   state_e state_q, state_d;

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic            fifo_empty, fifo_full, fifo_push, fifo_pop;

   logic            drop_d, hd_set, hd_clr, eid_we, len_we;
   logic            header_done_q, frame_dropped_q, is_fragment_q;
   logic [7:0]      header_eid_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   // Same slot index, opposite wrap bit: the FIFO holds FIFO_DEPTH entries.
   assign fifo_full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                       (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
   assign fifo_pop   = out_re && !fifo_empty;

   always_comb begin
      state_d   = state_q;
      in_next   = 1'b0;
      fifo_push = 1'b0;
      drop_d    = 1'b0;
      hd_set    = 1'b0;
      hd_clr    = 1'b0;
      eid_we    = 1'b0;
      len_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               in_next = 1'b1;
               if (in_last) begin
                  drop_d = 1'b1;
               end else if (in_data == MSG_TYPE) begin
                  state_d = StHEid;
               end else begin
                  state_d = StDiscard;
               end
            end
         end
         StHEid: begin
            if (in_valid) begin
               in_next = 1'b1;
               eid_we  = 1'b1;
               if (in_last) begin
                  drop_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StHLen;
               end
            end
         end
         StHLen: begin
            if (in_valid) begin
               in_next = 1'b1;
               len_we  = 1'b1;
               // A length byte that ends the frame means no payload: never accepted.
               if (in_last) begin
                  drop_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  hd_set  = 1'b1;
                  state_d = StPayload;
               end
            end
         end
         StPayload: begin
            if (in_valid && (!fifo_full || fifo_pop)) begin
               in_next   = 1'b1;
               fifo_push = 1'b1;
               if (in_last) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            if (fifo_empty) begin
               hd_clr  = 1'b1;
               state_d = StIdle;
            end
         end
         StDiscard: begin
            if (in_valid) begin
               in_next = 1'b1;
               if (in_last) begin
                  drop_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         header_done_q   <= 1'b0;
         frame_dropped_q <= 1'b0;
         header_eid_q    <= 8'h00;
         is_fragment_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         frame_dropped_q <= drop_d;
         if (hd_set) begin
            header_done_q <= 1'b1;
         end else if (hd_clr) begin
            header_done_q <= 1'b0;
         end
         if (eid_we) begin
            header_eid_q <= in_data;
         end
         if (len_we) begin
            is_fragment_q <= (in_data == 8'hFF);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         if (fifo_push) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= in_data;
            wr_ptr_q                  <= wr_ptr_q + PtrW'(1);
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

`ifdef EIN_FETCH_LEN_CHECK_EN
   logic [7:0] len_q, cnt_q;
   logic       len_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q     <= 8'h00;
         cnt_q     <= 8'h00;
         len_err_q <= 1'b0;
      end else if (len_we) begin
         len_q     <= in_data;
         cnt_q     <= 8'h00;
         len_err_q <= 1'b0;
      end else if (fifo_push) begin
         cnt_q <= cnt_q + 8'd1;
         // The byte being pushed is included in the count compared at frame end.
         if (in_last && !is_fragment_q && ((cnt_q + 8'd1) != len_q)) begin
            len_err_q <= 1'b1;
         end
      end
   end

   assign length_error = len_err_q;
`else
   assign length_error = 1'b0;
`endif

   assign out_data      = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[IdxW-1:0]];
   assign out_empty     = fifo_empty;
   assign header_done   = header_done_q;
   assign header_eid    = header_eid_q;
   assign is_fragment   = is_fragment_q;
   assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_ein_frame_fetch.sv
// Scoreboard bench for ein_frame_fetch: a byte source queue feeds the DUT, expected payload
// bytes are queued at stimulus time and compared as the modulator side pops them.
module tb_ein_frame_fetch;

`ifdef EIN_FETCH_LEN_CHECK_EN
   localparam logic LenChk = 1'b1;
`else
   localparam logic LenChk = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_next;
   logic [7:0] out_data;
   logic       out_empty;
   logic       out_re;
   logic       header_done;
   logic [7:0] header_eid;
   logic       is_fragment;
   logic       frame_dropped;
   logic       length_error;

   ein_frame_fetch #(
      .MSG_TYPE  (8'h65),
      .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_next      (in_next),
      .out_data     (out_data),
      .out_empty    (out_empty),
      .out_re       (out_re),
      .header_done  (header_done),
      .header_eid   (header_eid),
      .is_fragment  (is_fragment),
      .frame_dropped(frame_dropped),
      .length_error (length_error)
   );

   always #5 clk = ~clk;

   logic [8:0] src[$];
   logic [7:0] sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         pops = 0;
   int         drop_cnt = 0;
   bit         hd_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_head();
      if (src.size() > 0) begin
         in_valid = 1'b1;
         {in_last, in_data} = src[0];
      end else begin
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_data  = 8'h00;
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic last);
      src.push_back({last, d});
      drive_head();
   endtask

   // One clock: monitor on the falling edge, advance the source just after the rising edge.
   task automatic step();
      logic pop_now;
      @(negedge clk);
      if (out_re && !out_empty) begin
         check("hd_during_payload", header_done, 1);
         if (sb.size() == 0) check("sb_underflow", 1, 0);
         else check("payload", out_data, sb.pop_front());
      end
      if (frame_dropped) drop_cnt++;
      if (header_done) hd_seen = 1'b1;
      pop_now = in_next && in_valid;
      @(posedge clk);
      #1;
      if (pop_now && src.size() > 0) begin
         void'(src.pop_front());
         pops++;
      end
      drive_head();
   endtask

   task automatic run_until_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (src.size() == 0 && sb.size() == 0 && !header_done) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check("drain_done", done, 1);
      step();
      step();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_next"}, in_next, 0);
      check({tag, "_out_empty"}, out_empty, 1);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_hd"}, header_done, 0);
      check({tag, "_eid"}, header_eid, 0);
      check({tag, "_frag"}, is_fragment, 0);
      check({tag, "_dropped"}, frame_dropped, 0);
      check({tag, "_len_err"}, length_error, 0);
   endtask

   initial begin
      int d0;
      reset  = 1'b1;
      out_re = 1'b0;
      drive_head();
      #1;
      check_reset_vals("rst");
      step();
      step();
      reset = 1'b0;
      step();

      // Normal frame with continuous streaming
      out_re = 1'b1;
      push_byte(8'h65, 0); push_byte(8'h07, 0); push_byte(8'h03, 0);
      push_byte(8'hA1, 0); push_byte(8'hA2, 0); push_byte(8'hA3, 1);
      sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
      step();
      step();
      check("hd_before_len", header_done, 0);
      step();
      check("hd_rise", header_done, 1);
      check("eid_normal", header_eid, 8'h07);
      check("frag_normal", is_fragment, 0);
      step();
      check("first_empty", out_empty, 0);
      check("first_data", out_data, 8'hA1);
      run_until_idle(50);
      check("hd_fall", header_done, 0);
      check("len_err_normal", length_error, 0);

      // Wrong type: whole frame discarded
      d0 = drop_cnt; hd_seen = 1'b0; pops = 0;
      push_byte(8'h66, 0);
      for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), i == 4);
      run_until_idle(50);
      check("wrong_pops", pops, 6);
      check("wrong_drops", drop_cnt - d0, 1);
      check("wrong_hd", hd_seen, 0);

      // Truncated header, then zero-payload frame
      d0 = drop_cnt; hd_seen = 1'b0;
      push_byte(8'h65, 0); push_byte(8'h0B, 1);
      push_byte(8'h65, 0); push_byte(8'h0E, 0); push_byte(8'h03, 1);
      run_until_idle(50);
      check("trunc_drops", drop_cnt - d0, 2);
      check("trunc_hd", hd_seen, 0);

      // Backpressure: 10-byte payload, modulator stalled
      out_re = 1'b0; pops = 0;
      push_byte(8'h65, 0); push_byte(8'h08, 0); push_byte(8'h0A, 0);
      for (int i = 0; i < 10; i++) begin
         push_byte(8'hB0 + 8'(i), i == 9);
         sb.push_back(8'hB0 + 8'(i));
      end
      for (int i = 0; i < 20; i++) step();
      check("bp_pops", pops, 7);
      check("bp_in_next", in_next, 0);
      check("bp_in_valid", in_valid, 1);
      check("bp_empty", out_empty, 0);
      check("bp_head", out_data, 8'hB0);
      out_re = 1'b1;
      run_until_idle(100);
      check("bp_total_pops", pops, 13);
      check("bp_eid", header_eid, 8'h08);

      // Fragment
      push_byte(8'h65, 0); push_byte(8'h09, 0); push_byte(8'hFF, 0);
      push_byte(8'hC0, 0); push_byte(8'hC1, 1);
      sb.push_back(8'hC0); sb.push_back(8'hC1);
      run_until_idle(50);
      check("frag_flag", is_fragment, 1);
      check("frag_eid", header_eid, 8'h09);
      check("frag_len_err", length_error, 0);

      // Length mismatch: len 4, two payload bytes
      push_byte(8'h65, 0); push_byte(8'h0A, 0); push_byte(8'h04, 0);
      push_byte(8'hD0, 0); push_byte(8'hD1, 1);
      sb.push_back(8'hD0); sb.push_back(8'hD1);
      run_until_idle(50);
      check("lenchk_err", length_error, LenChk);
      check("lenchk_frag", is_fragment, 0);

      // Reset two cycles into payload
      out_re = 1'b0;
      push_byte(8'h65, 0); push_byte(8'h0C, 0); push_byte(8'h05, 0);
      for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i), i == 4);
      step(); step(); step();
      check("mid_hd", header_done, 1);
      step(); step();
      check("mid_buffered", out_empty, 0);
      src.delete();
      drive_head();
      reset = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      d0 = drop_cnt;
      step(); step();
      reset = 1'b0;
      step();
      check("mid_no_drop", drop_cnt - d0, 0);

      // Clean frame after reset
      out_re = 1'b1;
      push_byte(8'h65, 0); push_byte(8'h0D, 0); push_byte(8'h02, 0);
      push_byte(8'hF0, 0); push_byte(8'hF1, 1);
      sb.push_back(8'hF0); sb.push_back(8'hF1);
      run_until_idle(50);
      check("post_rst_eid", header_eid, 8'h0D);
      check("post_rst_sb", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
